// File: rtl/register.sv
// General-purpose edge-triggered storage register with write enable.
// Holds one WIDTH-bit word; asynchronous active-low reset forces RESET_VALUE.
module register #(
   parameter int                WIDTH       = 32,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Reset wins over a coincident enabled edge; otherwise load or hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         q <= RESET_VALUE;
      else if (enable)
         q <= d;
   end

endmodule

// File: tb/tb_register.sv
// Bench for register: default 32-bit instance and an 8-bit instance with
// RESET_VALUE 8'hFF, both compared against a behavioural reference.
module tb_register;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [31:0] d32;
   logic [31:0] q32;
   logic [7:0]  d8;
   logic [7:0]  q8;

   logic [31:0] m32;
   logic [7:0]  m8;

   int total;
   int passed;

   register u_dut32 (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .d      (d32),
      .q      (q32)
   );

   register #(.WIDTH(8), .RESET_VALUE(8'hFF)) u_dut8 (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .d      (d8),
      .q      (q8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic chk_both(input string tag);
      chk({tag, "_w32"}, q32, m32);
      chk({tag, "_w8"}, {24'h0, q8}, {24'h0, m8});
   endtask

   // Reference: the value a register would hold after the coming edge.
   task automatic tick();
      logic [31:0] n32;
      logic [7:0]  n8;
      n32 = m32;
      n8  = m8;
      if (!reset) begin
         n32 = 32'h0;
         n8  = 8'hFF;
      end else if (enable) begin
         n32 = d32;
         n8  = d8;
      end
      @(posedge clk);
      #1;
      m32 = n32;
      m8  = n8;
   endtask

   task automatic set_reset(input logic v);
      reset = v;
      if (!v) begin
         m32 = 32'h0;
         m8  = 8'hFF;
      end
      #1;
   endtask

   initial begin
      total  = 0;
      passed = 0;
      reset  = 1'b1;
      enable = 1'b0;
      d32    = 32'h0;
      d8     = 8'h0;
      m32    = 32'hx;
      m8     = 8'hx;

      // Asynchronous reset before any clock edge
      #2;
      set_reset(1'b0);
      chk("reset_async", q32, 32'h0000_0000);
      chk("reset_async_w8", {24'h0, q8}, 32'h0000_00FF);
      tick();
      chk_both("reset_held_edge");
      set_reset(1'b1);
      chk_both("reset_release");
      tick();
      chk("reset_release_edge", q32, 32'h0000_0000);

      // Single load then hold
      enable = 1'b1;
      d32 = 32'hA5A5_A5A5;
      d8  = 8'h3C;
      tick();
      enable = 1'b0;
      chk("load", q32, 32'hA5A5_A5A5);
      chk("load_w8", {24'h0, q8}, 32'h0000_003C);
      for (int i = 0; i < 3; i++) begin
         d32 = $urandom;
         d8  = 8'($urandom);
         tick();
         chk("hold", q32, 32'hA5A5_A5A5);
         chk("hold_w8", {24'h0, q8}, 32'h0000_003C);
      end

      // Overwrite
      enable = 1'b1;
      d32 = 32'h5A5A_5A5A;
      d8  = 8'hC3;
      tick();
      enable = 1'b0;
      d32 = 32'h1234_5678;
      chk("overwrite", q32, 32'h5A5A_5A5A);
      tick();
      chk("overwrite_hold", q32, 32'h5A5A_5A5A);

      // Reset pulse between edges, then reset across an enabled edge
      set_reset(1'b0);
      chk("pulse_low", q32, 32'h0000_0000);
      chk("pulse_low_w8", {24'h0, q8}, 32'h0000_00FF);
      set_reset(1'b1);
      chk_both("pulse_release");
      enable = 1'b1;
      d32 = 32'hDEAD_BEEF;
      d8  = 8'h11;
      set_reset(1'b0);
      tick();
      chk("reset_vs_enable", q32, 32'h0000_0000);
      chk("reset_vs_enable_w8", {24'h0, q8}, 32'h0000_00FF);
      enable = 1'b0;
      set_reset(1'b1);

      // Back-to-back loads
      enable = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         d32 = 32'(i);
         d8  = 8'(i);
         tick();
         chk("pipeline", q32, 32'(i));
         chk("pipeline_w8", {24'h0, q8}, 32'(i));
      end
      enable = 1'b0;

      // Randomized traffic against the reference
      for (int i = 0; i < 300; i++) begin
         enable = 1'($urandom_range(0, 1));
         d32    = $urandom;
         d8     = 8'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            set_reset(1'b0);
            chk_both("rand_pulse");
            set_reset(1'b1);
         end
         if ($urandom_range(0, 11) == 0) begin
            set_reset(1'b0);
            tick();
            chk_both("rand_reset_edge");
            set_reset(1'b1);
         end else begin
            tick();
            chk_both("rand");
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/register.md
Name: register

Overview:
- Parameterised edge-triggered data register with a write enable. Default width is 32 bits.
- Holds one data word; loads the input word on a rising clock edge when enabled.
- Used as a general storage element in the CPU datapath: PC, pipeline/latch registers and similar holding stages.
- Purely sequential: no combinational path from d to q.

Parameters:
- WIDTH, 32, data width in bits of d and q; must be 1 or greater.
- RESET_VALUE, {WIDTH{1'b0}}, value forced onto q while reset is asserted.

Ports:
- clk  input  1  system clock; all loads occur on its rising edge.
- reset  input  1  asynchronous, active-low reset; while 0, q is forced to RESET_VALUE.
- enable  input  1  write enable, active-high, sampled on the rising edge of clk.
- d  input  WIDTH  data word to be loaded.
- q  output  WIDTH  registered stored word.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset assertion (reset falls to 0):
  - q becomes RESET_VALUE immediately, without waiting for a clk edge.
  - q stays at RESET_VALUE for as long as reset is 0, regardless of clk, enable or d.
- Reset deassertion (reset rises to 1):
  - No change to q at the moment of release.
  - The first load can occur on the next rising clk edge with enable=1.
- Priority: reset over enable over hold.
- Load:
  - On rising clk with reset=1 and enable=1, q <= d.
  - Latency is 1 cycle: the new value is visible after the edge and stable for the following cycle.
- Hold:
  - On rising clk with reset=1 and enable=0, q keeps its previous value.
  - Changes on d have no effect on q between edges or while enable=0.
- Power-up: q is undefined (X in simulation) until the first reset assertion or the first enabled load. Benches must apply reset before checking q.
- Enable and d must be stable around the rising edge (standard setup/hold). No glitch filtering is performed.
- Reset mid-operation: a reset asserted at any time, including coincident with an enabled edge, yields q = RESET_VALUE. The concurrent load is discarded.
- Width rules:
  - d and q are exactly WIDTH bits; no extension or truncation is performed internally.
  - RESET_VALUE is truncated or zero-extended to WIDTH per standard Verilog assignment rules.
- Back-to-back loads: with enable held at 1, q follows d with a one-cycle delay on every edge.
- No other outputs or status flags.

Test Plan:
- Reset: drive reset=0 with enable=0 and d=0 -> q=32'h00000000 immediately, without a clk edge; release reset=1 -> q stays 32'h00000000.
- Load: enable=1, d=32'hA5A5A5A5 for one rising edge, then enable=0 -> q=32'hA5A5A5A5 after that edge.
- Hold: change d to other values with enable=0 over several edges -> q remains 32'hA5A5A5A5.
- Overwrite: enable=1, d=32'h5A5A5A5A for one edge, then enable=0 -> q=32'h5A5A5A5A and holds.
- Reset after data:
  - With q=32'h5A5A5A5A, pulse reset=0 between clock edges -> q=32'h00000000 at once and after release.
  - With enable=1 and reset=0 across an edge -> q stays 32'h00000000.
- Pipelined enable: enable=1 while d steps through 1, 2, 3 on successive edges -> q shows 1, 2, 3, each one cycle after the corresponding d.
  - Repeat with WIDTH=8, RESET_VALUE=8'hFF -> reset gives q=8'hFF.
